alu_seq: RTL

//  Parametrised, registered successor to the 8-bit combinational ALU. Same 16 opcodes, plus iterative

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/result bundle between the register file, the sequential ALU and write-back.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       F;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flag_ld;
    logic [5:0]       flags_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] D_HI;
    logic [5:0]       flags;

    // Requester / consumer side
    modport master (
        output in_valid, F, A, B, flag_ld, flags_in, out_ready,
        input  in_ready, out_valid, D, D_HI, flags
    );

    // ALU side
    modport slave (
        input  in_valid, F, A, B, flag_ld, flags_in, out_ready,
        output in_ready, out_valid, D, D_HI, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with 16 single-cycle ops, iterative unsigned MUL/DIV,
// a {S,Z,H,PV,N,C} flag register supplying Cin, and valid/ready handshakes.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_MOV  = 5'd0;
    localparam logic [4:0] OP_INC  = 5'd1;
    localparam logic [4:0] OP_INCC = 5'd2;
    localparam logic [4:0] OP_DEC  = 5'd3;
    localparam logic [4:0] OP_DECC = 5'd4;
    localparam logic [4:0] OP_ADD  = 5'd5;
    localparam logic [4:0] OP_ADC  = 5'd6;
    localparam logic [4:0] OP_SUB  = 5'd7;
    localparam logic [4:0] OP_SBC  = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;
    localparam logic [4:0] OP_OR   = 5'd10;
    localparam logic [4:0] OP_XOR  = 5'd11;
    localparam logic [4:0] OP_RR   = 5'd12;
    localparam logic [4:0] OP_RL   = 5'd13;
    localparam logic [4:0] OP_RRC  = 5'd14;
    localparam logic [4:0] OP_RLC  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;
    localparam logic [4:0] OP_DIV  = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 1 when the vector holds an even number of ones
    function automatic logic even_par(input logic [WIDTH-1:0] v);
        even_par = ~(^v);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // MUL: running high half, DIV: partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;        // MUL: multiplier/low half, DIV: dividend/quotient
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] d_hi_q, d_hi_d;
    logic [5:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             cin_s;

    logic [WIDTH-1:0] ar_op1_s, ar_op2_s, ar_res_s;
    logic             ar_cin_s, ar_sub_s, ar_c_s, ar_h_s, ar_pv_s;
    logic [WIDTH:0]   add_ext_s, sub_ext_s, ar_ext_s;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s, alu_h_s, alu_n_s, alu_pv_s, alu_is_ar_s;
    logic [5:0]       alu_flags_s;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH-1:0] div_trial_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] step_acc_s, step_mq_s;
    logic [5:0]       done_flags_s;

    assign in_ready_s = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;
    assign cin_s      = flags_q[0];

    // Operand/carry selection for the add/subtract family
    always_comb begin
        ar_op1_s = {WIDTH{1'b0}};
        ar_op2_s = {WIDTH{1'b0}};
        ar_cin_s = 1'b0;
        ar_sub_s = 1'b0;
        case (bus.F)
            OP_INC:  begin ar_op1_s = bus.B; ar_cin_s = 1'b1; end
            OP_INCC: begin ar_op1_s = bus.B; ar_cin_s = cin_s; end
            OP_DEC:  begin ar_op1_s = bus.B; ar_cin_s = 1'b1; ar_sub_s = 1'b1; end
            OP_DECC: begin ar_op1_s = bus.B; ar_cin_s = cin_s; ar_sub_s = 1'b1; end
            OP_ADD:  begin ar_op1_s = bus.A; ar_op2_s = bus.B; end
            OP_ADC:  begin ar_op1_s = bus.A; ar_op2_s = bus.B; ar_cin_s = cin_s; end
            OP_SUB:  begin ar_op1_s = bus.A; ar_op2_s = bus.B; ar_sub_s = 1'b1; end
            OP_SBC:  begin ar_op1_s = bus.A; ar_op2_s = bus.B; ar_cin_s = cin_s; ar_sub_s = 1'b1; end
            default: begin ar_op1_s = {WIDTH{1'b0}}; end
        endcase
    end

    assign add_ext_s = {1'b0, ar_op1_s} + {1'b0, ar_op2_s} + {{WIDTH{1'b0}}, ar_cin_s};
    assign sub_ext_s = {1'b0, ar_op1_s} - {1'b0, ar_op2_s} - {{WIDTH{1'b0}}, ar_cin_s};
    assign ar_ext_s  = ar_sub_s ? sub_ext_s : add_ext_s;
    assign ar_res_s  = ar_ext_s[WIDTH-1:0];
    assign ar_c_s    = ar_ext_s[WIDTH];
    // carry/borrow into bit 4 is recovered from the sum bit without a separate nibble adder
    assign ar_h_s    = ar_op1_s[4] ^ ar_op2_s[4] ^ ar_res_s[4];

    // Signed overflow: same-sign add or opposite-sign subtract that flips the sign of op1
    always_comb begin
        if (ar_sub_s) begin
            ar_pv_s = (ar_op1_s[WIDTH-1] != ar_op2_s[WIDTH-1]) & (ar_res_s[WIDTH-1] != ar_op1_s[WIDTH-1]);
        end else begin
            ar_pv_s = (ar_op1_s[WIDTH-1] == ar_op2_s[WIDTH-1]) & (ar_res_s[WIDTH-1] != ar_op1_s[WIDTH-1]);
        end
    end

    // Single-cycle result and flags; unused opcodes fall through to MOV
    always_comb begin
        alu_res_s   = bus.B;
        alu_c_s     = 1'b0;
        alu_h_s     = 1'b0;
        alu_n_s     = 1'b0;
        alu_is_ar_s = 1'b0;
        case (bus.F)
            OP_INC, OP_INCC, OP_ADD, OP_ADC: begin
                alu_res_s = ar_res_s; alu_c_s = ar_c_s; alu_h_s = ar_h_s; alu_is_ar_s = 1'b1;
            end
            OP_DEC, OP_DECC, OP_SUB, OP_SBC: begin
                alu_res_s = ar_res_s; alu_c_s = ar_c_s; alu_h_s = ar_h_s; alu_n_s = 1'b1;
                alu_is_ar_s = 1'b1;
            end
            OP_AND: alu_res_s = bus.A & bus.B;
            OP_OR:  alu_res_s = bus.A | bus.B;
            OP_XOR: alu_res_s = bus.A ^ bus.B;
            OP_RR:  begin alu_res_s = {cin_s, bus.B[WIDTH-1:1]};        alu_c_s = bus.B[0]; end
            OP_RL:  begin alu_res_s = {bus.B[WIDTH-2:0], cin_s};        alu_c_s = bus.B[WIDTH-1]; end
            OP_RRC: begin alu_res_s = {bus.B[0], bus.B[WIDTH-1:1]};     alu_c_s = bus.B[0]; end
            OP_RLC: begin alu_res_s = {bus.B[WIDTH-2:0], bus.B[WIDTH-1]}; alu_c_s = bus.B[WIDTH-1]; end
            OP_MOV: alu_res_s = bus.B;
            default: alu_res_s = bus.B;
        endcase
        if (alu_is_ar_s) begin
            alu_pv_s = ar_pv_s;
        end else begin
            alu_pv_s = even_par(alu_res_s);
        end
        alu_flags_s = {alu_res_s[WIDTH-1], (alu_res_s == {WIDTH{1'b0}}), alu_h_s,
                       alu_pv_s, alu_n_s, alu_c_s};
    end

    assign mul_sum_s   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {acc_q, mq_q[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, b_q});
    // when div_ge_s holds the true difference is below the divisor, so WIDTH bits suffice
    assign div_trial_s = div_shift_s[WIDTH-1:0] - b_q;

    // One shift-add (MUL) or restoring-subtract (DIV) iteration
    always_comb begin
        if (is_div_q) begin
            step_acc_s = div_ge_s ? div_trial_s : div_shift_s[WIDTH-1:0];
            step_mq_s  = {mq_q[WIDTH-2:0], div_ge_s};
        end else begin
            step_acc_s = mul_sum_s[WIDTH:1];
            step_mq_s  = {mul_sum_s[0], mq_q[WIDTH-1:1]};
        end
    end

    // Flags of the multi-cycle result, taken from the final iteration
    always_comb begin
        if (is_div_q) begin
            done_flags_s = {step_mq_s[WIDTH-1], (step_mq_s == {WIDTH{1'b0}}), 1'b0, 1'b0, 1'b0,
                            (b_q == {WIDTH{1'b0}})};
        end else begin
            done_flags_s = {step_acc_s[WIDTH-1],
                            (step_acc_s == {WIDTH{1'b0}}) & (step_mq_s == {WIDTH{1'b0}}),
                            1'b0, (step_acc_s != {WIDTH{1'b0}}), 1'b0,
                            (step_acc_s != {WIDTH{1'b0}})};
        end
    end

    // Next-state: accept (from IDLE or DONE), iterate in BUSY, hand off or hold in DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        d_d         = d_q;
        d_hi_d      = d_hi_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        if (accept_s) begin
            if ((bus.F == OP_MUL) || (bus.F == OP_DIV)) begin
                state_d     = ST_BUSY;
                cnt_d       = CNT_W'(WIDTH);
                is_div_d    = (bus.F == OP_DIV);
                b_d         = bus.B;
                acc_d       = {WIDTH{1'b0}};
                mq_d        = bus.A;
                out_valid_d = 1'b0;
            end else begin
                state_d     = ST_DONE;
                d_d         = alu_res_s;
                d_hi_d      = {WIDTH{1'b0}};
                flags_d     = alu_flags_s;
                out_valid_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.flag_ld) begin
                        flags_d = bus.flags_in;
                    end else begin
                        flags_d = flags_q;
                    end
                end
                ST_BUSY: begin
                    acc_d = step_acc_s;
                    mq_d  = step_mq_s;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d     = ST_DONE;
                        d_d         = step_mq_s;
                        d_hi_d      = step_acc_s;
                        flags_d     = done_flags_s;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            is_div_q    <= 1'b0;
            b_q         <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            mq_q        <= {WIDTH{1'b0}};
            d_q         <= {WIDTH{1'b0}};
            d_hi_q      <= {WIDTH{1'b0}};
            flags_q     <= 6'b000000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mq_q        <= mq_d;
            d_q         <= d_d;
            d_hi_q      <= d_hi_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;
    assign bus.D_HI      = d_hi_q;
    assign bus.flags     = flags_q;
endmodule
